uart_frac_baud_gen: RTL and testbench

//  Parametrised baud-tick generator for the next-generation CoreUART datapath.

---
 rtl/uart_frac_baud_gen.sv | 109 ++++++++++
 tb/tb_uart_frac_baud_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frac_baud_gen.sv
// Baud-tick generator: divides clk into an oversample tick (OVS per bit) and a per-bit xmit pulse.
// Optional fractional period trim is compiled in when UART_BAUD_FRAC_EN is defined.
module uart_frac_baud_gen #(
  parameter int CNT_W  = 13,
  parameter int FRAC_W = 3,
  parameter int OVS    = 16,
  parameter int OVS_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              restart,
  input  logic [CNT_W-1:0]  baud_val,
  input  logic [FRAC_W-1:0] baud_frac,
  output logic              baud_tick,
  output logic              xmit_pulse,
  output logic [OVS_W-1:0]  ovs_phase
);

  // ovs_phase wraps by natural overflow, so OVS must be exactly 2**OVS_W.
  if (OVS != (1 << OVS_W)) begin : g_ovs_check
    $error("uart_frac_baud_gen: OVS must equal 2**OVS_W");
  end

  logic [CNT_W-1:0] baud_cntr;
  logic [CNT_W-1:0] cntr_nxt;
  logic [OVS_W-1:0] phase_nxt;
  logic             tick_nxt;
  logic             xmit_nxt;
  logic             stretch;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_acc;
  logic [FRAC_W-1:0] acc_nxt;
  logic              stretch_nxt;
  logic [FRAC_W:0]   frac_sum;

  // Carry out of the accumulator lengthens the following period by one clk.
  assign frac_sum = {1'b0, frac_acc} + {1'b0, baud_frac};
`else
  logic unused_frac;

  assign stretch     = 1'b0;
  assign unused_frac = ^baud_frac;
`endif

  always_comb begin
    cntr_nxt  = baud_cntr;
    phase_nxt = ovs_phase;
    tick_nxt  = 1'b0;
    xmit_nxt  = 1'b0;
`ifdef UART_BAUD_FRAC_EN
    acc_nxt     = frac_acc;
    stretch_nxt = stretch;
`endif
    if (restart) begin
      cntr_nxt  = baud_val;
      phase_nxt = '0;
`ifdef UART_BAUD_FRAC_EN
      acc_nxt     = '0;
      stretch_nxt = 1'b0;
`endif
    end else if (!enable) begin
      cntr_nxt = baud_cntr;
    end else if (baud_cntr != '0) begin
      cntr_nxt = baud_cntr - CNT_W'(1);
    end else if (stretch) begin
`ifdef UART_BAUD_FRAC_EN
      stretch_nxt = 1'b0;
`endif
    end else begin
      cntr_nxt  = baud_val;
      tick_nxt  = 1'b1;
      phase_nxt = ovs_phase + OVS_W'(1);
      xmit_nxt  = (ovs_phase == OVS_W'(OVS - 1));
`ifdef UART_BAUD_FRAC_EN
      acc_nxt     = frac_sum[FRAC_W-1:0];
      stretch_nxt = frac_sum[FRAC_W];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cntr  <= '0;
      ovs_phase  <= '0;
      baud_tick  <= 1'b0;
      xmit_pulse <= 1'b0;
    end else begin
      baud_cntr  <= cntr_nxt;
      ovs_phase  <= phase_nxt;
      baud_tick  <= tick_nxt;
      xmit_pulse <= xmit_nxt;
    end
  end

`ifdef UART_BAUD_FRAC_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frac_acc <= '0;
      stretch  <= 1'b0;
    end else begin
      frac_acc <= acc_nxt;
      stretch  <= stretch_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// Directed bench for uart_frac_baud_gen; expected values follow the macro UART_BAUD_FRAC_EN.
module tb_uart_frac_baud_gen;

  localparam int CNT_W  = 13;
  localparam int FRAC_W = 3;
  localparam int OVS    = 16;
  localparam int OVS_W  = 4;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic              restart;
  logic [CNT_W-1:0]  baud_val;
  logic [FRAC_W-1:0] baud_frac;
  logic              baud_tick;
  logic              xmit_pulse;
  logic [OVS_W-1:0]  ovs_phase;

  int total;
  int bad;

  uart_frac_baud_gen #(
    .CNT_W (CNT_W),
    .FRAC_W(FRAC_W),
    .OVS   (OVS),
    .OVS_W (OVS_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .restart   (restart),
    .baud_val  (baud_val),
    .baud_frac (baud_frac),
    .baud_tick (baud_tick),
    .xmit_pulse(xmit_pulse),
    .ovs_phase (ovs_phase)
  );

  // clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // sample #1 after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // clocks until the next baud_tick, bounded; returns max on timeout
  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!baud_tick && n < max);
  endtask

  int n;
  int sum;
  int cnt;

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    enable = 1'b0;
    restart = 1'b0;
    baud_val = CNT_W'(3);
    baud_frac = '0;
    #3;
    check("rst_tick", baud_tick, 0);
    check("rst_xmit", xmit_pulse, 0);
    check("rst_phase", ovs_phase, 0);
    step();
    step();
    reset_n = 1'b1;

    // 1: baud_val=3 -> tick every 4 clks, xmit on phase wrap 15->0
    enable = 1'b1;
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("t1_restart_phase", ovs_phase, 0);
    check("t1_restart_tick", baud_tick, 0);
    wait_tick(40, n);
    check("t1_first_period", n, 4);
    check("t1_first_phase", ovs_phase, 1);
    check("t1_first_xmit", xmit_pulse, 0);
    for (int i = 2; i < 16; i++) begin
      wait_tick(40, n);
      check("t1_period", n, 4);
      check("t1_phase", ovs_phase, i);
    end
    wait_tick(40, n);
    check("t1_wrap_period", n, 4);
    check("t1_wrap_phase", ovs_phase, 0);
    check("t1_wrap_xmit", xmit_pulse, 1);
    step();
    check("t1_after_tick", baud_tick, 0);
    check("t1_after_xmit", xmit_pulse, 0);

    // 4: freeze at baud_cntr=2 for 10 clks
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (baud_tick) cnt++;
    end
    check("t4_frozen_ticks", cnt, 0);
    check("t4_frozen_phase", ovs_phase, 0);
    enable = 1'b1;
    wait_tick(40, n);
    check("t4_resume_period", n, 3);
    check("t4_resume_phase", ovs_phase, 1);

    // 5: restart at phase 9 with baud_val=5
    for (int i = 0; i < 8; i++) wait_tick(40, n);
    check("t5_pre_phase", ovs_phase, 9);
    baud_val = CNT_W'(5);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("t5_restart_phase", ovs_phase, 0);
    check("t5_restart_tick", baud_tick, 0);
    wait_tick(40, n);
    check("t5_first_period", n, 6);
    check("t5_first_phase", ovs_phase, 1);
    enable = 1'b0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    enable = 1'b1;
    check("t5_dis_restart_phase", ovs_phase, 0);
    wait_tick(40, n);
    check("t5_dis_restart_period", n, 6);

    // 6: baud_val 3 -> 7 mid-period, then async reset
    baud_val = CNT_W'(3);
    restart = 1'b1;
    step();
    restart = 1'b0;
    wait_tick(40, n);
    check("t6_old_first", n, 4);
    step();
    step();
    baud_val = CNT_W'(7);
    wait_tick(40, n);
    check("t6_old_rest", n, 2);
    wait_tick(40, n);
    check("t6_new_period_a", n, 8);
    wait_tick(40, n);
    check("t6_new_period_b", n, 8);
    check("t6_pre_rst_tick", baud_tick, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_tick", baud_tick, 0);
    check("t6_async_xmit", xmit_pulse, 0);
    check("t6_async_phase", ovs_phase, 0);
    step();
    reset_n = 1'b1;

    // 2: baud_val=3, frac=4 -> periods 4,4,5,4,... ; 16 ticks after the first span 72
    baud_val = CNT_W'(3);
    baud_frac = FRAC_W'(4);
    restart = 1'b1;
    step();
    restart = 1'b0;
    wait_tick(40, n);
    check("t2_first", n, 4);
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      wait_tick(40, n);
      sum += n;
      if (i == 1) begin
`ifdef UART_BAUD_FRAC_EN
        check("t2_stretched", n, 5);
`else
        check("t2_stretched", n, 4);
`endif
      end
    end
`ifdef UART_BAUD_FRAC_EN
    check("t2_span16", sum, 72);
`else
    check("t2_span16", sum, 64);
`endif

    // 3: baud_val=0, frac=7 -> 8 periods span 15 clks
    baud_val = CNT_W'(0);
    baud_frac = FRAC_W'(7);
    restart = 1'b1;
    step();
    restart = 1'b0;
    wait_tick(40, n);
    check("t3_first", n, 1);
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      wait_tick(40, n);
      sum += n;
    end
`ifdef UART_BAUD_FRAC_EN
    check("t3_span8", sum, 15);
`else
    check("t3_span8", sum, 8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
